// File: rtl/pirisc_pkg.sv
// Shared definitions for the pirisc front end: data width, the NOP used for
// misaligned fetches and the fetch FSM state encoding.
package pirisc_pkg;

  localparam int          DWIDTH_DEF   = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC input/flush, instruction memory port and decode handoff.
// master = the fetch unit, slave = everything around it.
interface instr_fetch_if #(
  parameter int DWIDTH = pirisc_pkg::DWIDTH_DEF
);
  logic [DWIDTH-1:0] pc_in;
  logic              flush;
  logic              imem_req;
  logic [DWIDTH-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DWIDTH-1:0] imem_rdata;
  logic              inst_valid;
  logic [DWIDTH-1:0] inst_out;
  logic [DWIDTH-1:0] inst_pc;
  logic              inst_ready;
  logic              inst_misaligned;
  logic              pc_en;

  modport master (
    input  pc_in, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_misaligned, pc_en
  );

  modport slave (
    output pc_in, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_misaligned, pc_en
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: one memory read per PC, result
// held for decode until accepted or flushed.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | latch pc_in; misaligned -> NOP straight to HOLD, else to REQ
// REQ      | imem_req high with latched address until granted
// WAIT     | granted, waiting for the single read beat
// DRAIN    | flushed with a read in flight; swallow the beat, then IDLE
// HOLD     | inst_valid high, outputs frozen until decode takes it
module instr_fetch
  import pirisc_pkg::*;
#(
  parameter int                DWIDTH   = DWIDTH_DEF,
  parameter logic [DWIDTH-1:0] NOP_INST = DWIDTH'(NOP_INST_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  fetch_state_t      state;
  logic [DWIDTH-1:0] fetch_addr;
  logic              req_q;
  logic              valid_q;
  logic [DWIDTH-1:0] inst_q;
  logic [DWIDTH-1:0] inst_pc_q;
  logic              misaligned_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      fetch_addr   <= '0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          fetch_addr <= bus.pc_in;
          if (!bus.flush) begin
            if (is_misaligned(bus.pc_in[1:0])) begin
              inst_q       <= NOP_INST;
              inst_pc_q    <= bus.pc_in;
              misaligned_q <= 1'b1;
              valid_q      <= 1'b1;
              state        <= ST_HOLD;
            end else begin
              req_q <= 1'b1;
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus.imem_gnt) begin
            req_q <= 1'b0;
            state <= bus.flush ? ST_DRAIN : ST_WAIT;
          end else if (bus.flush) begin
            req_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            if (bus.flush) begin
              state <= ST_IDLE;
            end else begin
              inst_q       <= bus.imem_rdata;
              inst_pc_q    <= fetch_addr;
              misaligned_q <= 1'b0;
              valid_q      <= 1'b1;
              state        <= ST_HOLD;
            end
          end else if (bus.flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.imem_rvalid) state <= ST_IDLE;
        end
        ST_HOLD: begin
          // flush wins over inst_ready; either way the slot is released
          if (bus.flush || bus.inst_ready) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req        = req_q;
  assign bus.imem_addr       = fetch_addr;
  assign bus.inst_valid      = valid_q;
  assign bus.inst_out        = inst_q;
  assign bus.inst_pc         = inst_pc_q;
  assign bus.inst_misaligned = misaligned_q;
  assign bus.pc_en           = (state == ST_HOLD) && bus.inst_ready && !bus.flush;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: latency, misalignment, stalls, flush cases
// and asynchronous reset, with hand-computed expectations.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  instr_fetch_if #(.DWIDTH(32)) bus ();

  instr_fetch #(.DWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    bus.pc_in       = '0;
    bus.flush       = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    zero_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pc_in = 32'h104; bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF; bus.inst_ready = 1'b1;
    tick();
    tick();
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got %b expected 0", bus.imem_req); end
    tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %h expected 0", bus.imem_addr); end
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b expected 0", bus.inst_valid); end
    tests_run++; if (bus.inst_out !== 32'h0) begin tests_failed++; $display("FAIL reset_out got %h expected 0", bus.inst_out); end
    tests_run++; if (bus.inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h expected 0", bus.inst_pc); end
    tests_run++; if (bus.inst_misaligned !== 1'b0) begin tests_failed++; $display("FAIL reset_mis got %b expected 0", bus.inst_misaligned); end
    tests_run++; if (bus.pc_en !== 1'b0) begin tests_failed++; $display("FAIL reset_pc_en got %b expected 0", bus.pc_en); end
  endtask

  task automatic test_basic();
    int en_cnt = 0;
    int first_valid = -1;
    apply_reset();
    bus.pc_in = 32'h100; bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h0050_0093; bus.inst_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (bus.inst_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (bus.pc_en === 1'b1) en_cnt++;
      if (c == 1) begin
        tests_run++; if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL basic_req got %b expected 1", bus.imem_req); end
        tests_run++; if (bus.imem_addr !== 32'h100) begin tests_failed++; $display("FAIL basic_addr got %h expected 100", bus.imem_addr); end
      end
      if (c == 3) begin
        tests_run++; if (bus.inst_out !== 32'h0050_0093) begin tests_failed++; $display("FAIL basic_out got %h expected 00500093", bus.inst_out); end
        tests_run++; if (bus.inst_pc !== 32'h100) begin tests_failed++; $display("FAIL basic_pc got %h expected 100", bus.inst_pc); end
        tests_run++; if (bus.inst_misaligned !== 1'b0) begin tests_failed++; $display("FAIL basic_mis got %b expected 0", bus.inst_misaligned); end
      end
    end
    tests_run++; if (first_valid !== 3) begin tests_failed++; $display("FAIL basic_latency got %0d expected 3", first_valid); end
    tests_run++; if (en_cnt !== 1) begin tests_failed++; $display("FAIL basic_pc_en_count got %0d expected 1", en_cnt); end
  endtask

  task automatic test_misaligned();
    int req_seen = 0;
    apply_reset();
    bus.pc_in = 32'h102; bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (bus.imem_req === 1'b1) req_seen++;
    end
    tests_run++; if (req_seen !== 0) begin tests_failed++; $display("FAIL mis_no_req got %0d expected 0", req_seen); end
    tests_run++; if (bus.inst_valid !== 1'b1) begin tests_failed++; $display("FAIL mis_valid got %b expected 1", bus.inst_valid); end
    tests_run++; if (bus.inst_out !== 32'h0000_0013) begin tests_failed++; $display("FAIL mis_out got %h expected 00000013", bus.inst_out); end
    tests_run++; if (bus.inst_misaligned !== 1'b1) begin tests_failed++; $display("FAIL mis_flag got %b expected 1", bus.inst_misaligned); end
    tests_run++; if (bus.inst_pc !== 32'h102) begin tests_failed++; $display("FAIL mis_pc got %h expected 102", bus.inst_pc); end
    bus.inst_ready = 1'b1;
    #1;
    tests_run++; if (bus.pc_en !== 1'b1) begin tests_failed++; $display("FAIL mis_pc_en got %b expected 1", bus.pc_en); end
  endtask

  task automatic test_stall();
    apply_reset();
    bus.pc_in = 32'h200;
    for (int c = 1; c <= 3; c++) begin
      tick();
      bus.pc_in = 32'h300;
      tests_run++; if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL stall_req c%0d got %b expected 1", c, bus.imem_req); end
      tests_run++; if (bus.imem_addr !== 32'h200) begin tests_failed++; $display("FAIL stall_addr c%0d got %h expected 200", c, bus.imem_addr); end
    end
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_req_drop got %b expected 0", bus.imem_req); end
    tick();
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_early_valid got %b expected 0", bus.inst_valid); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA5A5_0001;
    tick();
    bus.imem_rvalid = 1'b0;
    tests_run++; if (bus.inst_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid got %b expected 1", bus.inst_valid); end
    tests_run++; if (bus.inst_out !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL stall_out got %h expected a5a50001", bus.inst_out); end
    tests_run++; if (bus.inst_pc !== 32'h200) begin tests_failed++; $display("FAIL stall_pc got %h expected 200", bus.inst_pc); end
    // a stray beat while holding must not overwrite the captured word
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h5A5A_0002;
    tick();
    bus.imem_rvalid = 1'b0;
    tests_run++; if (bus.inst_out !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL stall_single_capture got %h expected a5a50001", bus.inst_out); end
  endtask

  task automatic test_flush_wait();
    int valid_seen = 0;
    apply_reset();
    bus.pc_in = 32'h400; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1;
    tick();
    tick();
    bus.imem_gnt = 1'b0; bus.flush = 1'b1; bus.pc_in = 32'h500;
    tick();
    bus.flush = 1'b0;
    if (bus.inst_valid === 1'b1) valid_seen++;
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL fw_drain_req got %b expected 0", bus.imem_req); end
    tick();
    if (bus.inst_valid === 1'b1) valid_seen++;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    if (bus.inst_valid === 1'b1) valid_seen++;
    bus.imem_rvalid = 1'b0; bus.imem_gnt = 1'b1;
    tick();
    if (bus.inst_valid === 1'b1) valid_seen++;
    tests_run++; if (valid_seen !== 0) begin tests_failed++; $display("FAIL fw_no_valid got %0d expected 0", valid_seen); end
    tests_run++; if (bus.inst_out !== 32'h0) begin tests_failed++; $display("FAIL fw_discard got %h expected 0", bus.inst_out); end
    tests_run++; if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL fw_new_req got %b expected 1", bus.imem_req); end
    tests_run++; if (bus.imem_addr !== 32'h500) begin tests_failed++; $display("FAIL fw_new_addr got %h expected 500", bus.imem_addr); end
  endtask

  task automatic test_hold_flush();
    int unstable = 0;
    int en_seen = 0;
    apply_reset();
    bus.pc_in = 32'h600; bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h1111_1111;
    tick(); tick(); tick();
    bus.imem_rdata = 32'h2222_2222;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'h1111_1111) unstable++;
      if (bus.pc_en === 1'b1) en_seen++;
    end
    tests_run++; if (unstable !== 0) begin tests_failed++; $display("FAIL hf_stable got %0d bad cycles expected 0", unstable); end
    tests_run++; if (en_seen !== 0) begin tests_failed++; $display("FAIL hf_no_pc_en got %0d expected 0", en_seen); end
    bus.flush = 1'b1; bus.inst_ready = 1'b1;
    #1;
    tests_run++; if (bus.pc_en !== 1'b0) begin tests_failed++; $display("FAIL hf_flush_pc_en got %b expected 0", bus.pc_en); end
    tick();
    bus.flush = 1'b0;
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL hf_valid_drop got %b expected 0", bus.inst_valid); end
    tick();
    tests_run++; if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL hf_refetch got %b expected 1", bus.imem_req); end
  endtask

  task automatic test_back_to_back();
    int en_cnt = 0;
    apply_reset();
    bus.pc_in = 32'h800; bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h0010_0113; bus.inst_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.pc_en === 1'b1) en_cnt++;
    end
    tests_run++; if (en_cnt !== 3) begin tests_failed++; $display("FAIL b2b_throughput got %0d expected 3", en_cnt); end
  endtask

  task automatic test_reset_mid();
    int valid_seen = 0;
    apply_reset();
    bus.pc_in = 32'h700; bus.imem_gnt = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL rm_addr got %h expected 0", bus.imem_addr); end
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rm_req got %b expected 0", bus.imem_req); end
    tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_valid got %b expected 0", bus.inst_valid); end
    tick();
    rst = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.inst_valid === 1'b1) valid_seen++;
    end
    bus.imem_rvalid = 1'b0;
    tests_run++; if (valid_seen !== 0) begin tests_failed++; $display("FAIL rm_ignore_valid got %0d expected 0", valid_seen); end
    tests_run++; if (bus.inst_out !== 32'h0) begin tests_failed++; $display("FAIL rm_ignore_out got %h expected 0", bus.inst_out); end
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_basic();
    test_misaligned();
    test_stall();
    test_flush_wait();
    test_hold_flush();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
